// File: rtl/merge_sort_ctrl.sv
// merge_sort_ctrl -- accepts two signed quartets, sorts each descending on
// entry, then merges them into one descending block of 8 samples through a
// valid/ready output port.
//
// Ports
//   clk       single clock, rising edge
//   rst       asynchronous reset, active-low
//   Flush     synchronous abort, active-high, beats every other event
//   BlkIn     input quartet valid
//   BlkReady  quartet may be accepted (high in S_A and S_B)
//   In1..In4  signed input quartet
//   SortOut   signed merged output sample
//   OutValid  SortOut valid
//   OutReady  downstream accepts SortOut
//   OutLast   marks the 8th sample of a merged block
//   Busy      high whenever the FSM is not in S_A
module merge_sort_ctrl #(
    parameter int W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                Flush,
    input  logic                BlkIn,
    output logic                BlkReady,
    input  logic signed [W-1:0] In1,
    input  logic signed [W-1:0] In2,
    input  logic signed [W-1:0] In3,
    input  logic signed [W-1:0] In4,
    output logic signed [W-1:0] SortOut,
    output logic                OutValid,
    input  logic                OutReady,
    output logic                OutLast,
    output logic                Busy
);

    typedef enum logic [1:0] {S_A, S_B, S_MERGE} state_t;
    typedef logic signed [W-1:0] sample_t;

    state_t     state, state_nxt;
    sample_t    buf_a [4];
    sample_t    buf_b [4];
    sample_t    sorted [4];
    sample_t    h01, l01, h23, l23, m_hi, m_lo;
    sample_t    a_head, b_head, pick_val;
    logic [2:0] ia, ib;
    logic       a_ok, b_ok, pick_a, pick_last;
    logic       accept, last_hs, load;

    // Five-comparator network: sort the pairs, take the outer extremes,
    // then order the two survivors in the middle. All operands are signed,
    // so the compares are signed and no arithmetic can overflow.
    always_comb begin
        h01       = (In1 >= In2) ? In1 : In2;
        l01       = (In1 >= In2) ? In2 : In1;
        h23       = (In3 >= In4) ? In3 : In4;
        l23       = (In3 >= In4) ? In4 : In3;
        sorted[0] = (h01 >= h23) ? h01 : h23;
        m_hi      = (h01 >= h23) ? h23 : h01;
        sorted[3] = (l01 >= l23) ? l23 : l01;
        m_lo      = (l01 >= l23) ? l01 : l23;
        sorted[1] = (m_hi >= m_lo) ? m_hi : m_lo;
        sorted[2] = (m_hi >= m_lo) ? m_lo : m_hi;
    end

    // Merge selection: a pointer value of 4 means that buffer is exhausted.
    // Ties go to A so equal samples leave in A-then-B order.
    always_comb begin
        a_ok      = !ia[2];
        b_ok      = !ib[2];
        a_head    = buf_a[ia[1:0]];
        b_head    = buf_b[ib[1:0]];
        pick_a    = a_ok && (!b_ok || (a_head >= b_head));
        pick_val  = pick_a ? a_head : b_head;
        pick_last = ({1'b0, ia} + {1'b0, ib}) == 4'd7;
    end

    assign BlkReady = (state != S_MERGE);
    assign Busy     = (state != S_A);
    assign accept   = BlkIn && BlkReady && !Flush;
    assign last_hs  = OutValid && OutReady && OutLast;
    // Load when the output register is empty (first sample) or is being
    // drained by a handshake, unless it already holds the last sample.
    assign load     = (state == S_MERGE) && (!OutValid || (OutReady && !OutLast));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_A;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers
            // sample the pre-edge values and ordering inside the block is moot.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        if (Flush) begin
            state_nxt = S_A;
        end else begin
            case (state)
                S_A:     if (accept)  state_nxt = S_B;
                S_B:     if (accept)  state_nxt = S_MERGE;
                S_MERGE: if (last_hs) state_nxt = S_A;
                default:              state_nxt = S_A;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ia       <= '0;
            ib       <= '0;
            SortOut  <= '0;
            OutValid <= 1'b0;
            OutLast  <= 1'b0;
        end else if (Flush) begin
            ia       <= '0;
            ib       <= '0;
            OutValid <= 1'b0;
            OutLast  <= 1'b0;
        end else if (load) begin
            SortOut  <= pick_val;
            OutValid <= 1'b1;
            OutLast  <= pick_last;
            if (pick_a) ia <= ia + 3'd1;
            else        ib <= ib + 3'd1;
        end else if (last_hs) begin
            ia       <= '0;
            ib       <= '0;
            OutValid <= 1'b0;
            OutLast  <= 1'b0;
        end
    end

    // NOTE: the quartet buffers carry no reset; they are always rewritten
    // before the merge reads them, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (accept && state == S_A) buf_a <= sorted;
        if (accept && state == S_B) buf_b <= sorted;
    end

endmodule

// File: doc/merge_sort_ctrl.md
MERGE_SORT_CTRL -- requirements
Module: merge_sort_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, sample width in bits (two's-complement signed).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Flush  input  1  synchronous abort, active-high.
REQ-005 SHALL have port BlkIn  input  1  input quartet valid.
REQ-006 SHALL have port BlkReady  output  1  input quartet may be accepted.
REQ-007 SHALL have ports In1, In2, In3, In4  input  W each  signed input quartet.
REQ-008 SHALL have port SortOut  output  W  signed merged output sample.
REQ-009 SHALL have port OutValid  output  1  SortOut valid.
REQ-010 SHALL have port OutReady  input  1  downstream accepts SortOut.
REQ-011 SHALL have port OutLast  output  1  marks the 8th sample of a merged block.
REQ-012 SHALL have port Busy  output  1  high whenever state is not S_A.

Function
REQ-013 SHALL implement FSM states S_A (await first quartet), S_B (await second quartet) and S_MERGE (emit 8 samples).
REQ-014 SHALL drive BlkReady = 1 in S_A and S_B and 0 in S_MERGE; a quartet is accepted on a rising edge with BlkIn && BlkReady.
REQ-015 SHALL sort each accepted quartet descending (max, second_max, second_min, min) with signed compare and store it in buffer A (from S_A) or buffer B (from S_B).
REQ-016 SHALL transition S_A->S_B on A-accept, S_B->S_MERGE on B-accept, and S_MERGE->S_A on the handshake of the sample carrying OutLast.
REQ-017 SHALL keep read pointers ia, ib (range 0..4) into A and B; a buffer with pointer 4 is exhausted and never selected.
REQ-018 SHALL select the next sample as the signed-larger of A[ia] and B[ib]; on ties SHALL select A (stable).
REQ-019 SHALL register SortOut/OutValid on the edge after B-accept (latency 1 cycle from B-accept to first OutValid).
REQ-020 SHALL treat an output handshake as OutValid && OutReady; on a handshake SHALL load the next selected sample on the same edge, or clear OutValid after the 8th.
REQ-021 SHALL hold SortOut, OutValid and OutLast stable while OutValid && !OutReady.
REQ-022 SHALL assert OutLast only together with the 8th sample of the block (ia + ib == 7 at selection).
REQ-023 SHALL ignore BlkIn in S_MERGE with no state change and no data loss in progress.
REQ-024 SHALL make BlkReady = 1 on the cycle after the last handshake (no stall cycle beyond the state register).
REQ-025 SHALL give Flush priority over all other synchronous events: state -> S_A, ia = ib = 0, OutValid = 0, OutLast = 0, buffered data discarded; a BlkIn on the same edge SHALL NOT be accepted.
REQ-026 SHALL handle W-bit extremes (-2^(W-1), 2^(W-1)-1) correctly without overflow (compare only, no arithmetic).

Reset
REQ-027 SHALL on rst = 0, immediately and independent of clk, force state S_A, ia = ib = 0, SortOut = 0, OutValid = 0, OutLast = 0, Busy = 0; BlkReady SHALL read 1 while in S_A.
REQ-028 SHALL resume normal operation on the first rising edge after rst returns to 1; reset mid-merge SHALL abandon the block with no further OutValid.

Verification
REQ-029 SHALL pass: A={3,-7,100,0}, B={-128,127,5,5}, OutReady=1 -> SortOut 127,100,5,5,3,0,-7,-128 on 8 consecutive cycles starting 1 cycle after B-accept, OutLast only on -128.
REQ-030 SHALL pass: A={5,5,5,5}, B={5,1,1,1} -> four A 5s, then B 5, then 1,1,1; internal source sequence A,A,A,A,B,B,B,B.
REQ-031 SHALL pass: case of REQ-029 with OutReady toggling 1,0,0,1,... -> identical sequence, no duplicate or drop, SortOut stable during every stall.
REQ-032 SHALL pass: BlkIn held high throughout -> exactly two quartets accepted per block, BlkReady 0 for all of S_MERGE, next A accepted the cycle after OutLast handshake.
REQ-033 SHALL pass: Flush asserted after 3rd output handshake, with BlkIn=1 on the same edge -> OutValid 0 next cycle, Busy 0, quartet not accepted; fresh block then merges correctly.
REQ-034 SHALL pass: rst pulled low mid-merge between clock edges -> OutValid/Busy 0 immediately, no output after release until two new quartets are accepted.
